// File: rtl/key_filter.sv
// Debounced key filter: 2-flop synchronizer, edge detect and a four-state
// confirmation FSM producing press, release and long-press pulses.
module key_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DB_TERM   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [LW-1:0] HOLD_TERM = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_ONE  = LW'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           prev_q, prev_d;
  logic [1:0]     fill_q, fill_d;
  logic           armed_q, armed_d;
  logic [DW-1:0]  db_cnt_q, db_cnt_d;
  logic [LW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           long_done_q, long_done_d;
  logic           key_state_q, key_state_d;
  logic           key_flag_q, key_flag_d;
  logic           key_press_q, key_press_d;
  logic           key_release_q, key_release_d;
  logic           key_long_q, key_long_d;
  logic           fall, rise;

  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;

  // Next-state logic for the synchronizer, counters, FSM and output pulses.
  always_comb begin
    sync1_d       = key_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    long_done_d   = long_done_q;
    key_state_d   = key_state_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    key_long_d    = 1'b0;

    // The synchronizer holds reset ones for two cycles; only arm once a real
    // high level has been seen, so a key held low through reset is ignored.
    if (fill_q != 2'd2) begin
      fill_d = fill_q + 2'd1;
    end else begin
      fill_d = fill_q;
    end
    armed_d = armed_q | ((fill_q == 2'd2) & sync2_q);

    if ((state_q == DOWN) || (state_q == FILTER_UP)) begin
      if (hold_cnt_q != HOLD_TERM) begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (fall && armed_q) begin
          state_d  = FILTER_DOWN;
          db_cnt_d = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      FILTER_DOWN: begin
        if (rise) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_TERM) begin
          state_d     = DOWN;
          key_press_d = 1'b1;
          key_state_d = 1'b0;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      DOWN: begin
        if (rise) begin
          state_d  = FILTER_UP;
          db_cnt_d = '0;
        end else begin
          state_d  = DOWN;
        end
      end
      FILTER_UP: begin
        if (fall) begin
          state_d = DOWN;
        end else if (db_cnt_q == DB_TERM) begin
          state_d       = IDLE;
          key_release_d = 1'b1;
          key_state_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A long pulse is dropped rather than overlap a release pulse.
    if (((state_q == DOWN) || (state_q == FILTER_UP)) && (hold_cnt_q == HOLD_TERM)
        && !long_done_q && !key_release_d) begin
      key_long_d  = 1'b1;
      long_done_d = 1'b1;
    end else begin
      key_long_d  = 1'b0;
    end

    key_flag_d = key_press_d | key_release_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      fill_q        <= 2'd0;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      long_done_q   <= 1'b0;
      key_state_q   <= 1'b1;
      key_flag_q    <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_done_q   <= long_done_d;
      key_state_q   <= key_state_d;
      key_flag_q    <= key_flag_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_flag    = key_flag_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter with short debounce/long-press parameters.
module tb_key_filter;

  localparam int unsigned DEB  = 16;
  localparam int unsigned LONG = 100;
  localparam int LAT = DEB + 3;

  localparam logic [2:0] K_PRESS   = 3'b001;
  localparam logic [2:0] K_RELEASE = 3'b010;
  localparam logic [2:0] K_LONG    = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic key_state, key_flag, key_press, key_release, key_long;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  key_filter #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk_50mhz  (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_flag   (key_flag),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Holds key_in at v for n cycles; entered and left at posedge + 1.
  task automatic drive(input logic v, input int n);
    key_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t       e;
    obs = {key_long, key_release, key_press};
    if (!rst && (obs != 3'b000 || key_flag)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got kind %b flag %b at cycle %0d, expected none",
                 obs, key_flag, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", int'(obs), int'(e.kind));
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_flag", int'(key_flag), int'((e.kind == K_PRESS) || (e.kind == K_RELEASE)));
        check("pulse_state", int'(key_state), int'(e.kind == K_RELEASE));
      end
    end
  end

  initial begin
    int t;
    int dur[10];
    dur = '{3, 1, 7, 2, 15, 4, 9, 1, 12, 5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", int'(key_state), 1);
    check("rst_flag", int'(key_flag), 0);
    check("rst_press", int'(key_press), 0);
    check("rst_release", int'(key_release), 0);
    check("rst_long", int'(key_long), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 10);

    // Clean press and release
    push(K_PRESS, cyc + LAT);
    drive(1'b0, 40);
    check("clean_down_state", int'(key_state), 0);
    push(K_RELEASE, cyc + LAT);
    drive(1'b1, 40);
    check("clean_up_state", int'(key_state), 1);

    // Bounce: ten short toggles, then held low
    for (int i = 0; i < 10; i++) drive(i[0] ? 1'b1 : 1'b0, dur[i]);
    push(K_PRESS, cyc + LAT);
    drive(1'b0, 40);
    push(K_RELEASE, cyc + LAT);
    drive(1'b1, 40);

    // Glitches of 15 and 16 cycles (16 hits terminal count with the rise)
    drive(1'b0, 15);
    drive(1'b1, 40);
    check("glitch15_state", int'(key_state), 1);
    drive(1'b0, 16);
    drive(1'b1, 40);
    check("glitch16_state", int'(key_state), 1);

    // 17-cycle low: shortest pulse that confirms
    t = cyc;
    push(K_PRESS, t + LAT);
    push(K_RELEASE, t + 17 + LAT);
    drive(1'b0, 17);
    drive(1'b1, 40);

    // Long press
    t = cyc;
    push(K_PRESS, t + LAT);
    push(K_LONG, t + LAT + 100);
    drive(1'b0, 200);
    check("long_held_state", int'(key_state), 0);
    push(K_RELEASE, cyc + LAT);
    drive(1'b1, 40);

    // Release bounce
    push(K_PRESS, cyc + LAT);
    drive(1'b0, 40);
    drive(1'b1, 8);
    drive(1'b0, 5);
    push(K_RELEASE, cyc + LAT);
    drive(1'b1, 40);

    // Reset while held down, key stays low afterwards
    push(K_PRESS, cyc + LAT);
    drive(1'b0, 40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold_state", int'(key_state), 1);
    @(posedge clk);
    #1;
    drive(1'b0, 200);
    check("rst_low_state", int'(key_state), 1);
    drive(1'b1, 40);
    check("rst_rearm_idle", int'(key_state), 1);
    push(K_PRESS, cyc + LAT);
    drive(1'b0, 40);
    push(K_RELEASE, cyc + LAT);
    drive(1'b1, 40);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_pulse: got nothing, expected kind %b at cycle %0d", e.kind, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
